// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, branch/jump flush, data-memory wait freeze and timeout.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned INIT_CYC    = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_branch_taken,
    input  logic              mem_access,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_flush,
    output logic              pipe_freeze,
    output logic              mem_timeout_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam int unsigned INIT_W = $clog2(INIT_CYC) + 1;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [INIT_W-1:0] init_cnt, init_nxt;
    logic              err_nxt;
    logic              apply_rules;
    logic              load_use;

    // Load in EX feeds a source of the instruction in ID; r0 is never a real dependency
    assign load_use = ex_memread && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_INIT;
            wait_cnt        <= '0;
            init_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_nxt;
            init_cnt        <= init_nxt;
            mem_timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        init_nxt     = init_cnt;
        err_nxt      = mem_timeout_err;
        apply_rules  = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;

        unique case (state)
            ST_INIT: begin
                pc_write     = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
                if (init_cnt == INIT_W'(INIT_CYC - 1)) begin
                    state_nxt = ST_RUN;
                    init_nxt  = '0;
                end else begin
                    init_nxt = init_cnt + INIT_W'(1);
                end
            end
            ST_RUN: begin
                if (mem_access && !mem_ready) begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    wait_nxt    = WAIT_W'(1);
                    state_nxt   = ST_MEM_WAIT;
                end else begin
                    apply_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    apply_rules = 1'b1;
                    state_nxt   = ST_RUN;
                end else begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_ERROR;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            ST_ERROR: begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            default: state_nxt = ST_INIT;
        endcase

        // Taken branch squashes younger work, so a coincident stall or jump is wrong-path
        if (apply_rules) begin
            if (mem_branch_taken) begin
                pc_write     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic stall_evt, flush_evt;

    assign stall_evt = apply_rules && !mem_branch_taken && load_use;
    assign flush_evt = apply_rules && (mem_branch_taken || (!load_use && id_jump));

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze}
    localparam logic [5:0] P_INIT   = 6'b011110;
    localparam logic [5:0] P_RUN    = 6'b110000;
    localparam logic [5:0] P_STALL  = 6'b000100;
    localparam logic [5:0] P_JUMP   = 6'b111000;
    localparam logic [5:0] P_BRANCH = 6'b111110;
    localparam logic [5:0] P_FREEZE = 6'b000001;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
    logic              id_uses_rt, id_jump, ex_memread;
    logic              mem_branch_taken, mem_access, mem_ready;
    logic              pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze;
    logic              mem_timeout_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic [5:0]        outs;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(
        .REG_AW(REG_AW), .MEM_TIMEOUT(4), .INIT_CYC(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush), .pipe_freeze(pipe_freeze),
        .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;
    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rt = 1'b0; id_jump = 1'b0; ex_memread = 1'b0;
        mem_branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        // T1: reset, then INIT_CYC flush cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 32'(outs), 32'(P_INIT));
        chk("rst_err", 32'(mem_timeout_err), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1 chk("init1", 32'(outs), 32'(P_INIT));
        tick();
        #1 chk("init2", 32'(outs), 32'(P_INIT));
        tick();
        clr();
        #1 chk("run_first", 32'(outs), 32'(P_RUN));
        chk("init_no_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();

        // T2: load-use via rs, via rt, and non-hazards
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1 chk("lu_rs", 32'(outs), 32'(P_STALL));
        tick();
        clr();
        #1 chk("lu_one_cycle", 32'(outs), 32'(P_RUN));
        chk("stall_cnt1", 32'(stall_cnt), cnt_exp(1));
        tick();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 chk("lu_r0", 32'(outs), 32'(P_RUN));
        tick();
        ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        #1 chk("lu_rt", 32'(outs), 32'(P_STALL));
        tick();
        id_uses_rt = 1'b0;
        #1 chk("lu_rt_unused", 32'(outs), 32'(P_RUN));
        tick();
        ex_memread = 1'b0; ex_rt = 5'd3;
        #1 chk("no_memread", 32'(outs), 32'(P_RUN));
        chk("stall_cnt2", 32'(stall_cnt), cnt_exp(2));
        tick();
        clr();
        id_jump = 1'b1;
        #1 chk("jump", 32'(outs), 32'(P_JUMP));
        tick();
        clr();
        #1 chk("flush_cnt1", 32'(flush_cnt), cnt_exp(1));

        // T3: branch wins over load-use and jump
        mem_branch_taken = 1'b1; id_jump = 1'b1;
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1 chk("branch_all", 32'(outs), 32'(P_BRANCH));
        tick();
        clr();
        #1 chk("branch_stall_cnt", 32'(stall_cnt), cnt_exp(2));
        chk("branch_flush_cnt", 32'(flush_cnt), cnt_exp(2));

        // T4: three freeze cycles, ready on the last allowed wait cycle
        mem_access = 1'b1;
        #1 chk("freeze1", 32'(outs), 32'(P_FREEZE));
        tick();
        #1 chk("freeze2", 32'(outs), 32'(P_FREEZE));
        tick();
        #1 chk("freeze3", 32'(outs), 32'(P_FREEZE));
        tick();
        mem_ready = 1'b1;
        #1 chk("ready_release", 32'(outs), 32'(P_RUN));
        tick();
        clr();
        #1 chk("back_in_run", 32'(outs), 32'(P_RUN));
        chk("no_err_boundary", 32'(mem_timeout_err), 32'd0);
        tick();
        mem_access = 1'b1; mem_ready = 1'b1;
        #1 chk("access_ready_now", 32'(outs), 32'(P_RUN));
        tick();
        mem_ready = 1'b0;
        #1 chk("freeze_j", 32'(outs), 32'(P_FREEZE));
        tick();
        mem_ready = 1'b1; id_jump = 1'b1;
        #1 chk("ready_jump", 32'(outs), 32'(P_JUMP));
        tick();
        clr();
        #1 chk("flush_cnt3", 32'(flush_cnt), cnt_exp(3));

        // T5: timeout after four freeze cycles, sticky error, async reset
        mem_access = 1'b1;
        #1 chk("to_freeze1", 32'(outs), 32'(P_FREEZE));
        tick(); tick(); tick();
        #1 chk("to_freeze4", 32'(outs), 32'(P_FREEZE));
        chk("to_err_pending", 32'(mem_timeout_err), 32'd0);
        tick();
        #1 chk("to_err_set", 32'(mem_timeout_err), 32'd1);
        chk("err_freeze", 32'(outs), 32'(P_FREEZE));
        mem_ready = 1'b1; mem_branch_taken = 1'b1;
        #1 chk("err_ignores_ready", 32'(outs), 32'(P_FREEZE));
        tick();
        #1 chk("err_sticky", 32'(mem_timeout_err), 32'd1);
        #2 reset = 1'b1;
        #1 chk("async_err_clr", 32'(mem_timeout_err), 32'd0);
        chk("async_init", 32'(outs), 32'(P_INIT));
        chk("async_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();
        clr();
        reset = 1'b0;
        tick(); tick();
        #1 chk("rerun", 32'(outs), 32'(P_RUN));

        // T6: stall counter saturation
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        repeat (20) tick();
        clr();
        #1 chk("stall_sat", 32'(stall_cnt), cnt_exp(15));
        chk("flush_after_sat", 32'(flush_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
